digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_adder.sv | 124 ++++++++++++
 tb/tb_digit_serial_adder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit add, DIGIT bits per clock, registered carry.
// Define DIGIT_SERIAL_ADDER_SUB_EN to add the sub port (a - b - cin).
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Ripple chain of full-adder cells over one digit.
    function automatic logic [DIGIT:0] fa_chain(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c0
    );
        logic             c;
        logic [DIGIT-1:0] s;
        c = c0;
        s = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    always_comb begin
        {dcarry, dsum} = fa_chain(a_sr[DIGIT-1:0], b_sr[DIGIT-1:0], carry);
    end

    generate
        if (DIGIT == WIDTH) begin : g_full
            assign sum_next = dsum;
        end else begin : g_part
            assign sum_next = {dsum, sum[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? ~cin : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b_in;
                        carry    <= c_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    sum   <= sum_next;
                    carry <= dcarry;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout      <= dcarry;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and throttled-random checks of digit_serial_adder.
// Sub-mode checks build when DIGIT_SERIAL_ADDER_SUB_EN is defined.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    logic        sub = 1'b0;
`endif

    logic        v1 = 1'b0, r1, ov1, or1 = 1'b1, c1, co1;
    logic [7:0]  a1 = '0, b1 = '0, s1;
    logic        v8 = 1'b0, r8, ov8, or8 = 1'b1, c8, co8;
    logic [7:0]  a8 = '0, b8 = '0, s8;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut_bit (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
        .a(a1), .b(b1), .cin(c1),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut_full (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
        .a(a8), .b(b8), .cin(c8),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
    );

    // Present operands at a negedge while idle; returns after the accept edge.
    task automatic drive_accept(input logic [15:0] va, input logic [15:0] vb,
                                input logic vc);
        int g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, cout} !== 3'b100) begin
            $display("FAIL reset_flags got=%b want=100",
                     {in_ready, out_valid, cout});
        end else pass_cnt++;
        total++;
        if (sum !== 16'h0000) begin
            $display("FAIL reset_sum got=%h want=0000", sum);
        end else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        out_ready = 1'b1;
        drive_accept(16'hFFFF, 16'h0001, 1'b0);
        wait_out(lat);
        total++;
        if (lat !== 4) begin
            $display("FAIL basic_latency got=%0d want=4", lat);
        end else pass_cnt++;
        total++;
        if ({cout, sum} !== 17'h10000) begin
            $display("FAIL basic_result got=%h want=10000", {cout, sum});
        end else pass_cnt++;
        total++;
        if (in_ready !== 1'b0) begin
            $display("FAIL basic_busy got=%b want=0", in_ready);
        end else pass_cnt++;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL basic_drain got=%b want=10",
                     {in_ready, out_valid});
        end else pass_cnt++;
    endtask

    task automatic test_hold;
        int lat;
        out_ready = 1'b0;
        drive_accept(16'h1234, 16'h4321, 1'b1);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 16'hFFFF;
            b = 16'hFFFF;
            cin = 1'b1;
            total++;
            if ({out_valid, in_ready, cout, sum} !== {3'b100, 16'h5556}) begin
                $display("FAIL hold_cycle%0d got=%b_%b_%b_%h want=1_0_0_5556",
                         i, out_valid, in_ready, cout, sum);
            end else pass_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL hold_release got=%b want=01",
                     {out_valid, in_ready});
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int lat;
        out_ready = 1'b1;
        drive_accept(16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, cout, sum} !== {3'b100, 16'h0000}) begin
            $display("FAIL midreset got=%b_%b_%b_%h want=1_0_0_0000",
                     in_ready, out_valid, cout, sum);
        end else pass_cnt++;
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL midreset_nopulse got=%b want=0", out_valid);
        end else pass_cnt++;
        drive_accept(16'h0003, 16'h0004, 1'b0);
        wait_out(lat);
        total++;
        if ({cout, sum} !== 17'h00007 || lat !== 4) begin
            $display("FAIL midreset_next got=%h lat=%0d want=00007 lat=4",
                     {cout, sum}, lat);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_corner_bit;
        int lat = 0;
        a1 = 8'h80;
        b1 = 8'h80;
        c1 = 1'b0;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        while (!ov1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 8 || {co1, s1} !== 9'h100) begin
            $display("FAIL corner_d1 got=%h lat=%0d want=100 lat=8",
                     {co1, s1}, lat);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_corner_full;
        int lat = 0;
        a8 = 8'h80;
        b8 = 8'h80;
        c8 = 1'b0;
        v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        while (!ov8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 1 || {co8, s8} !== 9'h100) begin
            $display("FAIL corner_d8 got=%h lat=%0d want=100 lat=1",
                     {co8, s8}, lat);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [16:0] exp_q[$];
        int rcvd = 0;
        int sent = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int g = 0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    a = 16'($urandom);
                    b = 16'($urandom);
                    cin = 1'($urandom);
                    in_valid = 1'b1;
                    while (!in_ready && g < 200) begin
                        @(negedge clk);
                        g++;
                    end
                    exp_q.push_back({1'b0, a} + {1'b0, b} + 17'(cin));
                    sent++;
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            begin
                int cyc = 0;
                while (rcvd < 100 && cyc < 20000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL b2b_extra got=%h want=none",
                                     {cout, sum});
                        end else begin
                            logic [16:0] e;
                            e = exp_q.pop_front();
                            if ({cout, sum} !== e) begin
                                $display("FAIL b2b_%0d got=%h want=%h",
                                         rcvd, {cout, sum}, e);
                            end else pass_cnt++;
                        end
                        rcvd++;
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rcvd !== 100 || sent !== 100 || exp_q.size() !== 0) begin
            $display("FAIL b2b_count got=%0d/%0d left=%0d want=100/100 left=0",
                     rcvd, sent, exp_q.size());
        end else pass_cnt++;
    endtask

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat;
        out_ready = 1'b1;
        sub = 1'b1;
        drive_accept(16'h0005, 16'h0007, 1'b0);
        wait_out(lat);
        total++;
        if ({cout, sum} !== 17'h0FFFE) begin
            $display("FAIL sub_borrow got=%h want=0fffe", {cout, sum});
        end else pass_cnt++;
        @(negedge clk);
        drive_accept(16'h0007, 16'h0005, 1'b1);
        wait_out(lat);
        total++;
        if ({cout, sum} !== 17'h10001) begin
            $display("FAIL sub_noborrow got=%h want=10001", {cout, sum});
        end else pass_cnt++;
        @(negedge clk);
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_reset_mid;
        test_corner_bit;
        test_corner_full;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
